dma_cfg_regfile: RTL and testbench

Channel-configuration register file serving the DMA channel config FSM. It is the responder for the config FSM's two read ports and its status write port, with its `regFile_writeReady` handshake. It also exposes a CPU-side write/read port and raises `CPU_interrupt_CFG` when the CPU commits a configuration. It sits between the AXI slave front-end and the channel config FSM.

---
 rtl/dma_cfg_pkg.sv | 12 +
 rtl/dma_wr_arbiter.sv | 31 +++
 rtl/dma_cfg_regfile.sv | 103 ++++++++++
 tb/tb_dma_cfg_regfile.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_cfg_pkg.sv
// Shared constants and types for the DMA channel-configuration register file.
package dma_cfg_pkg;

  localparam int CFG_CTRL_ADDR = 0;
  localparam int CFG_GO_BIT    = 0;

  typedef enum logic {
    SRC_CPU    = 1'b0,
    SRC_STATUS = 1'b1
  } wr_src_e;

endpackage

// File: rtl/dma_wr_arbiter.sv
// Two-way round-robin write arbiter between the CPU port and the status port.
module dma_wr_arbiter
  import dma_cfg_pkg::*;
(
  input  logic AXI_aclk,
  input  logic AXI_aresetn,
  input  logic cpu_req,
  input  logic sts_req,
  output logic cpu_gnt,
  output logic sts_gnt
);

  wr_src_e last_grant;

  // Grants are gated by reset so both readies read 0 while reset is held.
  always_comb begin
    cpu_gnt = AXI_aresetn && cpu_req && (!sts_req || (last_grant == SRC_STATUS));
    sts_gnt = AXI_aresetn && sts_req && (!cpu_req || (last_grant == SRC_CPU));
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      last_grant <= SRC_CPU;
    end else if (cpu_gnt) begin
      last_grant <= SRC_CPU;
    end else if (sts_gnt) begin
      last_grant <= SRC_STATUS;
    end
  end

endmodule

// File: rtl/dma_cfg_regfile.sv
// Channel-configuration register file: one arbitrated write port, three
// registered read ports with write-first forwarding, and a CPU GO interrupt.
module dma_cfg_regfile
  import dma_cfg_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 8,
  parameter int REGFILE_DATA_WIDTH = 32
) (
  input  logic                            AXI_aclk,
  input  logic                            AXI_aresetn,
  input  logic                            cpu_wr_valid,
  input  logic [REGFILE_ADDR_WIDTH-1:0]   cpu_wr_addr,
  input  logic [REGFILE_DATA_WIDTH-1:0]   cpu_wr_data,
  input  logic [REGFILE_DATA_WIDTH/8-1:0] cpu_wr_strb,
  output logic                            cpu_wr_ready,
  input  logic                            cpu_rd_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0]   cpu_rd_addr,
  output logic [REGFILE_DATA_WIDTH-1:0]   cpu_rd_data,
  input  logic                            regFile_writeEnable,
  input  logic [REGFILE_ADDR_WIDTH-1:0]   regFile_writeAddr,
  input  logic [REGFILE_DATA_WIDTH-1:0]   regFile_writeData,
  output logic                            regFile_writeReady,
  input  logic                            regFile_readEnable,
  input  logic [REGFILE_ADDR_WIDTH-1:0]   regFile_readAddr,
  output logic [REGFILE_DATA_WIDTH-1:0]   regFile_readData,
  input  logic                            regFile_readEnable2,
  input  logic [REGFILE_ADDR_WIDTH-1:0]   regFile_readAddr2,
  output logic [REGFILE_DATA_WIDTH-1:0]   regFile_readData2,
  output logic                            CPU_interrupt_CFG
);

  localparam int DEPTH  = 2 ** REGFILE_ADDR_WIDTH;
  localparam int STRB_W = REGFILE_DATA_WIDTH / 8;
  localparam logic [REGFILE_ADDR_WIDTH-1:0] CTRL_ADDR = REGFILE_ADDR_WIDTH'(CFG_CTRL_ADDR);

  logic [REGFILE_DATA_WIDTH-1:0] mem [DEPTH];

  logic                          cpu_gnt;
  logic                          sts_gnt;
  logic                          wr_en;
  logic [REGFILE_ADDR_WIDTH-1:0] wr_addr;
  logic [REGFILE_DATA_WIDTH-1:0] cpu_merged;
  logic [REGFILE_DATA_WIDTH-1:0] wr_data;
  logic                          go_hit;
  logic [REGFILE_DATA_WIDTH-1:0] cpu_rd_next;
  logic [REGFILE_DATA_WIDTH-1:0] rd1_next;
  logic [REGFILE_DATA_WIDTH-1:0] rd2_next;

  dma_wr_arbiter u_arb (
    .AXI_aclk    (AXI_aclk),
    .AXI_aresetn (AXI_aresetn),
    .cpu_req     (cpu_wr_valid),
    .sts_req     (regFile_writeEnable),
    .cpu_gnt     (cpu_gnt),
    .sts_gnt     (sts_gnt)
  );

  assign cpu_wr_ready       = cpu_gnt;
  assign regFile_writeReady = sts_gnt;

  // The GO bit is a command, never state, so it is cleared on every CTRL write.
  always_comb begin
    cpu_merged = mem[cpu_wr_addr];
    for (int b = 0; b < STRB_W; b++) begin
      if (cpu_wr_strb[b]) cpu_merged[b*8 +: 8] = cpu_wr_data[b*8 +: 8];
    end
    wr_en   = cpu_gnt || sts_gnt;
    wr_addr = cpu_gnt ? cpu_wr_addr : regFile_writeAddr;
    wr_data = cpu_gnt ? cpu_merged : regFile_writeData;
    if (wr_addr == CTRL_ADDR) wr_data[CFG_GO_BIT] = 1'b0;
    go_hit = cpu_gnt && (cpu_wr_addr == CTRL_ADDR)
             && cpu_wr_strb[CFG_GO_BIT / 8] && cpu_wr_data[CFG_GO_BIT];
  end

  always_comb begin
    cpu_rd_next = (wr_en && (wr_addr == cpu_rd_addr))       ? wr_data : mem[cpu_rd_addr];
    rd1_next    = (wr_en && (wr_addr == regFile_readAddr))  ? wr_data : mem[regFile_readAddr];
    rd2_next    = (wr_en && (wr_addr == regFile_readAddr2)) ? wr_data : mem[regFile_readAddr2];
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      cpu_rd_data       <= '0;
      regFile_readData  <= '0;
      regFile_readData2 <= '0;
      CPU_interrupt_CFG <= 1'b0;
    end else begin
      if (cpu_rd_en)           cpu_rd_data       <= cpu_rd_next;
      if (regFile_readEnable)  regFile_readData  <= rd1_next;
      if (regFile_readEnable2) regFile_readData2 <= rd2_next;
      CPU_interrupt_CFG <= go_hit;
    end
  end

endmodule

// File: tb/tb_dma_cfg_regfile.sv
// Directed-vector bench for dma_cfg_regfile with a queue-based read-data scoreboard.
module tb_dma_cfg_regfile;

  logic        AXI_aclk;
  logic        AXI_aresetn;
  logic        cpu_wr_valid;
  logic [7:0]  cpu_wr_addr;
  logic [31:0] cpu_wr_data;
  logic [3:0]  cpu_wr_strb;
  logic        cpu_wr_ready;
  logic        cpu_rd_en;
  logic [7:0]  cpu_rd_addr;
  logic [31:0] cpu_rd_data;
  logic        regFile_writeEnable;
  logic [7:0]  regFile_writeAddr;
  logic [31:0] regFile_writeData;
  logic        regFile_writeReady;
  logic        regFile_readEnable;
  logic [7:0]  regFile_readAddr;
  logic [31:0] regFile_readData;
  logic        regFile_readEnable2;
  logic [7:0]  regFile_readAddr2;
  logic [31:0] regFile_readData2;
  logic        CPU_interrupt_CFG;

  dma_cfg_regfile #(.REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32)) dut (
    .AXI_aclk            (AXI_aclk),
    .AXI_aresetn         (AXI_aresetn),
    .cpu_wr_valid        (cpu_wr_valid),
    .cpu_wr_addr         (cpu_wr_addr),
    .cpu_wr_data         (cpu_wr_data),
    .cpu_wr_strb         (cpu_wr_strb),
    .cpu_wr_ready        (cpu_wr_ready),
    .cpu_rd_en           (cpu_rd_en),
    .cpu_rd_addr         (cpu_rd_addr),
    .cpu_rd_data         (cpu_rd_data),
    .regFile_writeEnable (regFile_writeEnable),
    .regFile_writeAddr   (regFile_writeAddr),
    .regFile_writeData   (regFile_writeData),
    .regFile_writeReady  (regFile_writeReady),
    .regFile_readEnable  (regFile_readEnable),
    .regFile_readAddr    (regFile_readAddr),
    .regFile_readData    (regFile_readData),
    .regFile_readEnable2 (regFile_readEnable2),
    .regFile_readAddr2   (regFile_readAddr2),
    .regFile_readData2   (regFile_readData2),
    .CPU_interrupt_CFG   (CPU_interrupt_CFG)
  );

  initial AXI_aclk = 1'b0;
  always #5 AXI_aclk = ~AXI_aclk;

  typedef struct packed {
    logic        cpu_wv;
    logic [7:0]  cpu_wa;
    logic [31:0] cpu_wd;
    logic [3:0]  cpu_ws;
    logic        sts_wv;
    logic [7:0]  sts_wa;
    logic [31:0] sts_wd;
    logic        cpu_re;
    logic [7:0]  cpu_ra;
    logic [31:0] exp_cpu_rd;
    logic        r1_e;
    logic [7:0]  r1_a;
    logic [31:0] exp_r1;
    logic        r2_e;
    logic [7:0]  r2_a;
    logic [31:0] exp_r2;
    logic        exp_cpu_rdy;
    logic        exp_sts_rdy;
    logic        exp_irq;
  } vec_t;

  int vectors_applied = 0;
  int miscompares     = 0;
  vec_t v;
  logic [31:0] exp_cpu_q[$];
  logic [31:0] exp_r1_q[$];
  logic [31:0] exp_r2_q[$];
  logic pend_cpu, pend_r1, pend_r2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clr();
    v = '0;
  endtask

  task automatic cpuWr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    v.cpu_wv = 1'b1; v.cpu_wa = a; v.cpu_wd = d; v.cpu_ws = s; v.exp_cpu_rdy = 1'b1;
  endtask

  task automatic stsWr(input logic [7:0] a, input logic [31:0] d);
    v.sts_wv = 1'b1; v.sts_wa = a; v.sts_wd = d; v.exp_sts_rdy = 1'b1;
  endtask

  task automatic drive(input vec_t x);
    cpu_wr_valid        = x.cpu_wv;
    cpu_wr_addr         = x.cpu_wa;
    cpu_wr_data         = x.cpu_wd;
    cpu_wr_strb         = x.cpu_ws;
    regFile_writeEnable = x.sts_wv;
    regFile_writeAddr   = x.sts_wa;
    regFile_writeData   = x.sts_wd;
    cpu_rd_en           = x.cpu_re;
    cpu_rd_addr         = x.cpu_ra;
    regFile_readEnable  = x.r1_e;
    regFile_readAddr    = x.r1_a;
    regFile_readEnable2 = x.r2_e;
    regFile_readAddr2   = x.r2_a;
  endtask

  // One cycle: check the interrupt left by the previous edge, drive, check readies, queue reads.
  task automatic applyStimulus(input vec_t x);
    @(negedge AXI_aclk);
    checkOutput("irq", {31'd0, CPU_interrupt_CFG}, {31'd0, x.exp_irq});
    drive(x);
    #1;
    checkOutput("cpu_wr_ready", {31'd0, cpu_wr_ready}, {31'd0, x.exp_cpu_rdy});
    checkOutput("regFile_writeReady", {31'd0, regFile_writeReady}, {31'd0, x.exp_sts_rdy});
    if (x.cpu_re) exp_cpu_q.push_back(x.exp_cpu_rd);
    if (x.r1_e)   exp_r1_q.push_back(x.exp_r1);
    if (x.r2_e)   exp_r2_q.push_back(x.exp_r2);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cpu_wr_ready"}, {31'd0, cpu_wr_ready}, 32'd0);
    checkOutput({tag, "_writeReady"}, {31'd0, regFile_writeReady}, 32'd0);
    checkOutput({tag, "_irq"}, {31'd0, CPU_interrupt_CFG}, 32'd0);
    checkOutput({tag, "_cpu_rd_data"}, cpu_rd_data, 32'd0);
    checkOutput({tag, "_readData"}, regFile_readData, 32'd0);
    checkOutput({tag, "_readData2"}, regFile_readData2, 32'd0);
  endtask

  // Monitor: remember which ports were enabled at an edge, compare their data at the next falling edge.
  always @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      pend_cpu <= 1'b0; pend_r1 <= 1'b0; pend_r2 <= 1'b0;
    end else begin
      pend_cpu <= cpu_rd_en; pend_r1 <= regFile_readEnable; pend_r2 <= regFile_readEnable2;
    end
  end

  always @(negedge AXI_aclk) begin
    if (pend_cpu) begin
      if (exp_cpu_q.size() == 0) checkOutput("cpu_rd_unexpected", 32'd1, 32'd0);
      else checkOutput("cpu_rd_data", cpu_rd_data, exp_cpu_q.pop_front());
    end
    if (pend_r1) begin
      if (exp_r1_q.size() == 0) checkOutput("readData_unexpected", 32'd1, 32'd0);
      else checkOutput("readData", regFile_readData, exp_r1_q.pop_front());
    end
    if (pend_r2) begin
      if (exp_r2_q.size() == 0) checkOutput("readData2_unexpected", 32'd1, 32'd0);
      else checkOutput("readData2", regFile_readData2, exp_r2_q.pop_front());
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr();
    drive(v);
    AXI_aresetn  = 1'b0;
    cpu_wr_valid = 1'b1;
    regFile_writeEnable = 1'b1;
    repeat (2) @(posedge AXI_aclk);
    #1;
    checkResetOutputs("reset");
    clr(); drive(v);
    @(negedge AXI_aclk);
    AXI_aresetn = 1'b1;

    // Basic CPU write then port-1 read.
    clr(); cpuWr(8'h10, 32'hDEADBEEF, 4'hF); applyStimulus(v);
    clr(); v.r1_e = 1; v.r1_a = 8'h10; v.exp_r1 = 32'hDEADBEEF; applyStimulus(v);

    // Conflict after reset: status first, CPU holds and wins next.
    clr(); cpuWr(8'h20, 32'h1, 4'hF); stsWr(8'h21, 32'h2); v.exp_cpu_rdy = 0; applyStimulus(v);
    clr(); cpuWr(8'h20, 32'h1, 4'hF); applyStimulus(v);
    clr(); v.r1_e = 1; v.r1_a = 8'h20; v.exp_r1 = 32'h1;
    v.r2_e = 1; v.r2_a = 8'h21; v.exp_r2 = 32'h2; applyStimulus(v);

    // Conflict after a status grant: CPU wins.
    clr(); stsWr(8'h22, 32'h3); applyStimulus(v);
    clr(); cpuWr(8'h23, 32'h4, 4'hF); stsWr(8'h24, 32'h5); v.exp_sts_rdy = 0; applyStimulus(v);
    clr(); stsWr(8'h24, 32'h5); applyStimulus(v);
    clr(); v.r1_e = 1; v.r1_a = 8'h23; v.exp_r1 = 32'h4;
    v.r2_e = 1; v.r2_a = 8'h24; v.exp_r2 = 32'h5; applyStimulus(v);

    // Byte-strobe merge.
    clr(); cpuWr(8'h30, 32'hFFFFFFFF, 4'hF); applyStimulus(v);
    clr(); cpuWr(8'h30, 32'h00000000, 4'h2); applyStimulus(v);
    clr(); v.cpu_re = 1; v.cpu_ra = 8'h30; v.exp_cpu_rd = 32'hFFFF00FF; applyStimulus(v);

    // CTRL GO: one pulse, GO not stored; status write and unstrobed byte 0 do not pulse.
    clr(); cpuWr(8'h00, 32'h3, 4'hF); applyStimulus(v);
    clr(); v.exp_irq = 1; v.cpu_re = 1; v.cpu_ra = 8'h00; v.exp_cpu_rd = 32'h2; applyStimulus(v);
    clr(); stsWr(8'h00, 32'h1); applyStimulus(v);
    clr(); applyStimulus(v);
    clr(); cpuWr(8'h00, 32'h1, 4'hE); applyStimulus(v);
    clr(); applyStimulus(v);

    // Back-to-back GO writes give back-to-back pulses.
    clr(); cpuWr(8'h00, 32'h1, 4'hF); applyStimulus(v);
    clr(); cpuWr(8'h00, 32'h1, 4'hF); v.exp_irq = 1; applyStimulus(v);
    clr(); v.exp_irq = 1; applyStimulus(v);
    clr(); applyStimulus(v);

    // Write-first forwarding, full-word status and merged CPU.
    clr(); stsWr(8'h40, 32'hA5); v.r2_e = 1; v.r2_a = 8'h40; v.exp_r2 = 32'hA5; applyStimulus(v);
    clr(); cpuWr(8'h10, 32'h11, 4'h1); v.r1_e = 1; v.r1_a = 8'h10; v.exp_r1 = 32'hDEADBE11; applyStimulus(v);
    clr(); applyStimulus(v);
    checkOutput("readData2_hold", regFile_readData2, 32'hA5);

    // Reset during a granted write clears the array and drops the write.
    clr(); cpuWr(8'h51, 32'h0000ABCD, 4'hF); applyStimulus(v);
    clr(); cpuWr(8'h50, 32'h00001234, 4'hF); applyStimulus(v);
    AXI_aresetn = 1'b0;
    #1;
    checkResetOutputs("midreset");
    clr(); drive(v);
    @(negedge AXI_aclk);
    AXI_aresetn = 1'b1;
    clr(); v.r1_e = 1; v.r1_a = 8'h50; v.exp_r1 = 32'h0;
    v.r2_e = 1; v.r2_a = 8'h51; v.exp_r2 = 32'h0; applyStimulus(v);

    // Reset during the interrupt cycle cancels the pulse.
    clr(); cpuWr(8'h00, 32'h1, 4'hF); applyStimulus(v);
    @(posedge AXI_aclk);
    #1;
    clr(); drive(v);
    checkOutput("irq_before_reset", {31'd0, CPU_interrupt_CFG}, 32'd1);
    AXI_aresetn = 1'b0;
    #1;
    checkOutput("irq_in_reset", {31'd0, CPU_interrupt_CFG}, 32'd0);
    @(negedge AXI_aclk);
    AXI_aresetn = 1'b1;
    clr(); applyStimulus(v);
    clr(); applyStimulus(v);

    repeat (3) @(negedge AXI_aclk);
    #1;
    checkOutput("queues_drained", exp_cpu_q.size() + exp_r1_q.size() + exp_r2_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
